// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Valid/ready instruction handoff from the fetch stage to the execute pipeline.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [INSTR_W-1:0] InstrOut;
  logic               InstrValid;
  logic               OutReady;

  modport master (output InstrOut, output InstrValid, input OutReady);
  modport slave  (input InstrOut, input InstrValid, output OutReady);
endinterface

// File: rtl/instr_mem.sv
// Instruction store: synchronous write port, asynchronous read port, not reset.
module instr_mem
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic               clk,
  input  logic               wrEn,
  input  logic [ADDR_W-1:0]  wrAddr,
  input  logic [INSTR_W-1:0] wrData,
  input  logic [ADDR_W-1:0]  rdAddr,
  output logic [INSTR_W-1:0] rdData
);
  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: run/halt FSM walking the PC through instruction memory and
// issuing one word per cycle over a valid/ready handshake.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 6,
  parameter int unsigned        DEPTH     = 2 ** ADDR_W,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 LoadEn,
  input  logic [ADDR_W-1:0]    LoadAddr,
  input  logic [INSTR_W-1:0]   LoadData,
  input  logic                 Start,
  input  logic [ADDR_W:0]      ProgLen,
  instr_fetch_unit_if.master   outBus,
  output logic [ADDR_W-1:0]    PC,
  output logic                 Done
);
  localparam int unsigned LEN_W = ADDR_W + 1;

  fetch_state_t       stateQ, stateNext;
  logic [ADDR_W-1:0]  pcQ, pcNext;
  logic [LEN_W-1:0]   lenQ, lenNext;
  logic [INSTR_W-1:0] outQ, outNext;
  logic               validQ, validNext;
  logic               doneQ, doneNext;
  logic               memWe;
  logic               issue;
  logic [INSTR_W-1:0] rdData;

  instr_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) uMem (
    .clk    (clk),
    .wrEn   (memWe),
    .wrAddr (LoadAddr),
    .wrData (LoadData),
    .rdAddr (pcQ),
    .rdData (rdData)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ <= IDLE;
      pcQ    <= '0;
      lenQ   <= '0;
      outQ   <= '0;
      validQ <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateNext;
      pcQ    <= pcNext;
      lenQ   <= lenNext;
      outQ   <= outNext;
      validQ <= validNext;
      doneQ  <= doneNext;
    end
  end

  always_comb begin
    stateNext = stateQ;
    pcNext    = pcQ;
    lenNext   = lenQ;
    outNext   = outQ;
    validNext = validQ;
    memWe     = 1'b0;
    issue     = !validQ || outBus.OutReady;

    case (stateQ)
      IDLE: begin
        // Memory writes are blocked while reset is asserted so reset never corrupts the program.
        memWe = rst && LoadEn;
        if (Start && (ProgLen != '0)) begin
          lenNext   = (ProgLen > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : ProgLen;
          pcNext    = '0;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          if (rdData == HALT_WORD) begin
            validNext = 1'b0;
            stateNext = HALT;
          end else begin
            outNext   = rdData;
            validNext = 1'b1;
            pcNext    = pcQ + ADDR_W'(1);
            if ({1'b0, pcQ} == (lenQ - LEN_W'(1))) stateNext = HALT;
          end
        end
      end
      HALT: begin
        if (validQ && outBus.OutReady) validNext = 1'b0;
        if (Start && !validQ) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    doneNext = (stateNext == HALT);
  end

  assign outBus.InstrOut   = outQ;
  assign outBus.InstrValid = validQ;
  assign PC                = pcQ;
  assign Done              = doneQ;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with hand-written multi-cycle sequences.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        LoadEn;
  logic [5:0]  LoadAddr;
  logic [31:0] LoadData;
  logic        Start;
  logic [6:0]  ProgLen;
  logic [5:0]  PC;
  logic        Done;
  int          checks = 0;
  int          failures = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.ADDR_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .LoadEn   (LoadEn),
    .LoadAddr (LoadAddr),
    .LoadData (LoadData),
    .Start    (Start),
    .ProgLen  (ProgLen),
    .outBus   (bus.master),
    .PC       (PC),
    .Done     (Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rN;
    logic        le;
    logic [5:0]  la;
    logic [31:0] ld;
    logic        st;
    logic [6:0]  pl;
    logic        rdy;
    logic [31:0] eOut;
    logic        eV;
    logic [5:0]  ePc;
    logic        eD;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic rN, input logic le, input logic [5:0] la, input logic [31:0] ld,
                      input logic st, input logic [6:0] pl, input logic rdy,
                      input logic [31:0] eOut, input logic eV, input logic [5:0] ePc, input logic eD);
    vec_t v;
    v.rN = rN; v.le = le; v.la = la; v.ld = ld; v.st = st; v.pl = pl; v.rdy = rdy;
    v.eOut = eOut; v.eV = eV; v.ePc = ePc; v.eD = eD;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rN, input logic le, input logic [5:0] la, input logic [31:0] ld,
                       input logic st, input logic [6:0] pl, input logic rdy);
    rst = rN; LoadEn = le; LoadAddr = la; LoadData = ld; Start = st; ProgLen = pl; bus.OutReady = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", tag, idx, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int idx, input logic [31:0] eOut, input logic eV,
                          input logic [5:0] ePc, input logic eD);
    chk({tag, ".InstrOut"}, idx, bus.InstrOut, eOut);
    chk({tag, ".InstrValid"}, idx, 32'(bus.InstrValid), 32'(eV));
    chk({tag, ".PC"}, idx, 32'(PC), 32'(ePc));
    chk({tag, ".Done"}, idx, 32'(Done), 32'(eD));
  endtask

  initial begin
    drive(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 7'd0, 1'b0);

    // reset with Start/LoadEn asserted, load, ProgLen=0, basic run
    addv(0,1,0,32'hDEAD,1,3,1, 32'h0,0,0,0);
    addv(0,1,0,32'hDEAD,1,3,1, 32'h0,0,0,0);
    addv(1,1,0,32'h11,0,0,1,   32'h0,0,0,0);
    addv(1,1,1,32'h22,0,0,1,   32'h0,0,0,0);
    addv(1,1,2,32'h33,0,0,1,   32'h0,0,0,0);
    addv(1,0,0,32'h0,1,0,1,    32'h0,0,0,0);
    addv(1,0,0,32'h0,1,3,1,    32'h0,0,0,0);
    addv(1,0,0,32'h0,0,0,1,    32'h11,1,1,0);
    addv(1,0,0,32'h0,0,0,1,    32'h22,1,2,0);
    addv(1,0,0,32'h0,0,0,1,    32'h33,1,3,1);
    addv(1,0,0,32'h0,0,0,1,    32'h33,0,3,1);
    addv(1,0,0,32'h0,1,0,1,    32'h33,0,3,0);
    // stall with Start ignored in RUN and in HALT while a word is pending
    addv(1,0,0,32'h0,1,3,1,    32'h33,0,0,0);
    addv(1,0,0,32'h0,0,0,1,    32'h11,1,1,0);
    addv(1,0,0,32'h0,0,0,1,    32'h22,1,2,0);
    addv(1,0,0,32'h0,1,5,0,    32'h22,1,2,0);
    addv(1,0,0,32'h0,0,0,0,    32'h22,1,2,0);
    addv(1,0,0,32'h0,0,0,1,    32'h33,1,3,1);
    addv(1,0,0,32'h0,0,0,0,    32'h33,1,3,1);
    addv(1,0,0,32'h0,1,0,0,    32'h33,1,3,1);
    addv(1,0,0,32'h0,0,0,1,    32'h33,0,3,1);
    addv(1,0,0,32'h0,1,0,1,    32'h33,0,3,0);
    // halt word at address 1
    addv(1,1,0,32'hA,0,0,1,        32'h33,0,3,0);
    addv(1,1,1,32'hFFFFFFFF,0,0,1, 32'h33,0,3,0);
    addv(1,1,2,32'hB,0,0,1,        32'h33,0,3,0);
    addv(1,0,0,32'h0,1,3,1,        32'h33,0,0,0);
    addv(1,0,0,32'h0,0,0,1,        32'hA,1,1,0);
    addv(1,0,0,32'h0,0,0,1,        32'hA,0,1,1);
    addv(1,0,0,32'h0,0,0,1,        32'hA,0,1,1);
    addv(1,0,0,32'h0,1,0,1,        32'hA,0,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rN, vecs[i].le, vecs[i].la, vecs[i].ld, vecs[i].st, vecs[i].pl, vecs[i].rdy);
      step();
      checkAll("vec", i, vecs[i].eOut, vecs[i].eV, vecs[i].ePc, vecs[i].eD);
    end

    // ProgLen = DEPTH+5 over a full memory; a load attempted mid-run must be ignored
    for (int k = 0; k < 64; k++) begin
      drive(1'b1, 1'b1, 6'(k), 32'h100 + 32'(k), 1'b0, 7'd0, 1'b1);
      step();
    end
    drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 7'd69, 1'b1);
    step();
    checkAll("fullStart", 0, 32'hA, 1'b0, 6'd0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      drive(1'b1, k == 10, 6'd20, 32'hBEEF, 1'b0, 7'd0, 1'b1);
      step();
      checkAll("full", k, 32'h100 + 32'(k), 1'b1, 6'(k + 1), k == 63);
    end
    drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 7'd0, 1'b1);
    step();
    checkAll("fullEnd", 0, 32'h13F, 1'b0, 6'd0, 1'b1);
    step();
    checkAll("fullEnd", 1, 32'h13F, 1'b0, 6'd0, 1'b1);
    drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 7'd0, 1'b1);
    step();
    checkAll("fullIdle", 0, 32'h13F, 1'b0, 6'd0, 1'b0);

    // reset during a stall, with a load attempted under reset, then rerun
    drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 7'd3, 1'b1);
    step();
    checkAll("rstRun", 0, 32'h13F, 1'b0, 6'd0, 1'b0);
    drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 7'd0, 1'b1);
    step();
    checkAll("rstRun", 1, 32'h100, 1'b1, 6'd1, 1'b0);
    drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 7'd0, 1'b0);
    step();
    checkAll("rstRun", 2, 32'h100, 1'b1, 6'd1, 1'b0);
    drive(1'b0, 1'b1, 6'd1, 32'hBAD, 1'b1, 7'd3, 1'b0);
    step();
    checkAll("rstRun", 3, 32'h0, 1'b0, 6'd0, 1'b0);
    drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 7'd3, 1'b1);
    step();
    checkAll("rstRun", 4, 32'h0, 1'b0, 6'd0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 7'd0, 1'b1);
      step();
      checkAll("rerun", j, 32'h100 + 32'(j), 1'b1, 6'(j + 1), j == 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
